// File: rtl/evo_truth_table_sampler.sv
// ----------------------------------------------------------------------------
// evo_truth_table_sampler
//
// Characterises a 4-input / 1-output evolved combinational circuit whose output
// may oscillate or latch. The sweep drives all 16 input vectors in order. Each
// vector is held for SETTLE_CYCLES clocks and then sampled for SAMPLES clocks.
// The block records a truth table (the first sample taken for each vector) and
// an instability mask (set when any later sample differs from that first one).
//
// Optional feature (macro SAMPLER_TOGGLE_COUNT_EN):
//   defined   - toggle_count counts sample-to-sample changes of the
//               synchronised output over every sample window. It saturates at
//               16'hFFFF and is cleared when a start is accepted.
//   undefined - no counter logic; toggle_count is tied to 16'h0000.
//
// Ports:
//   clk           in   1   system clock
//   rst_n         in   1   asynchronous active-low reset
//   start         in   1   one-cycle sweep request, honoured only in IDLE
//   dut_in        out  4   vector applied to the circuit under test
//   dut_out       in   1   circuit output (asynchronous, 2-flop synchronised)
//   busy          out  1   high while a sweep is running
//   done          out  1   one-cycle pulse at the end of a sweep
//   truth_table   out 16   bit v = first synchronised sample for vector v
//   unstable_mask out 16   bit v = some sample for vector v differed from the first
//   toggle_count  out 16   sample-to-sample change count (see above)
// ----------------------------------------------------------------------------
module evo_truth_table_sampler #(
    parameter int SETTLE_CYCLES = 16,
    parameter int SAMPLES       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [3:0]  dut_in,
    input  logic        dut_out,
    output logic        busy,
    output logic        done,
    output logic [15:0] truth_table,
    output logic [15:0] unstable_mask,
    output logic [15:0] toggle_count
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int NW = $clog2(SAMPLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [SW-1:0]   settle_cnt_reg;
    logic [NW-1:0]   sample_cnt_reg;
    logic [3:0]      vec_reg;
    logic            sync_meta_reg;
    logic            sync_reg;
    logic            first_sample_reg;
    logic [15:0]     truth_table_reg;
    logic [15:0]     unstable_mask_reg;
    logic            settle_last;
    logic            sample_last;

    assign settle_last = (settle_cnt_reg == SW'(SETTLE_CYCLES - 1));
    assign sample_last = (sample_cnt_reg == NW'(SAMPLES - 1));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = SETTLE;
            SETTLE:  if (settle_last) state_next = SAMPLE;
            SAMPLE: begin
                if (sample_last) begin
                    state_next = (vec_reg == 4'hF) ? DONE : SETTLE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: synchroniser, counters, result capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta_reg     <= 1'b0;
            sync_reg          <= 1'b0;
            settle_cnt_reg    <= '0;
            sample_cnt_reg    <= '0;
            vec_reg           <= 4'h0;
            first_sample_reg  <= 1'b0;
            truth_table_reg   <= 16'h0000;
            unstable_mask_reg <= 16'h0000;
        end else begin
            // dut_out is unrelated to clk (the circuit may oscillate freely),
            // so it always passes through two flops before use.
            sync_meta_reg <= dut_out;
            sync_reg      <= sync_meta_reg;

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        vec_reg           <= 4'h0;
                        settle_cnt_reg    <= '0;
                        sample_cnt_reg    <= '0;
                        truth_table_reg   <= 16'h0000;
                        unstable_mask_reg <= 16'h0000;
                    end
                end
                SETTLE: begin
                    // The synchroniser delay (2 clocks) fits inside the
                    // settle window, so the first sample already reflects
                    // the current vector.
                    settle_cnt_reg <= settle_last ? '0 : settle_cnt_reg + 1'b1;
                    sample_cnt_reg <= '0;
                end
                SAMPLE: begin
                    if (sample_cnt_reg == '0) begin
                        truth_table_reg[vec_reg] <= sync_reg;
                        first_sample_reg         <= sync_reg;
                    end else if (sync_reg != first_sample_reg) begin
                        unstable_mask_reg[vec_reg] <= 1'b1;
                    end
                    if (sample_last) begin
                        sample_cnt_reg <= '0;
                        // vec stays at 15 after the last window so the
                        // circuit input does not move after the sweep.
                        if (vec_reg != 4'hF) begin
                            vec_reg <= vec_reg + 4'h1;
                        end
                    end else begin
                        sample_cnt_reg <= sample_cnt_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SAMPLER_TOGGLE_COUNT_EN
    logic        prev_sample_reg;
    logic [15:0] toggle_count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_sample_reg  <= 1'b0;
            toggle_count_reg <= 16'h0000;
        end else begin
            if (state_reg == IDLE && start) begin
                toggle_count_reg <= 16'h0000;
            end else if (state_reg == SAMPLE) begin
                prev_sample_reg <= sync_reg;
                // Only changes between samples of the same window count;
                // the jump from one vector's window to the next does not.
                if (sample_cnt_reg != '0 && sync_reg != prev_sample_reg &&
                    toggle_count_reg != 16'hFFFF) begin
                    toggle_count_reg <= toggle_count_reg + 16'h0001;
                end
            end
        end
    end

    assign toggle_count = toggle_count_reg;
`else
    assign toggle_count = 16'h0000;
`endif

    assign dut_in        = vec_reg;
    assign busy          = (state_reg == SETTLE) || (state_reg == SAMPLE);
    assign done          = (state_reg == DONE);
    assign truth_table   = truth_table_reg;
    assign unstable_mask = unstable_mask_reg;

endmodule

// File: tb/tb_evo_truth_table_sampler.sv
// Directed bench for evo_truth_table_sampler: a default instance (16/8) and a
// minimal-timing instance (2/1). Expected results are queued when a sweep is
// started and popped when done is seen.
module tb_evo_truth_table_sampler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  dut_in;
    logic        dut_out;
    logic        busy, done;
    logic [15:0] truth_table, unstable_mask, toggle_count;

    logic        start2 = 1'b0;
    logic [3:0]  dut_in2;
    logic        dut_out2 = 1'b0;
    logic        busy2, done2;
    logic [15:0] truth_table2, unstable_mask2, toggle_count2;

    int          mode = 0;       // 0: const 1, 1: in0^in3, 2: in0^in3 with toggling vector 7
    logic        tog = 1'b0;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;

    typedef struct {
        logic [15:0] tt;
        logic [15:0] tt_care;
        logic [15:0] um;
        logic [15:0] tc;
        int          done_at;
    } exp_t;
    exp_t sb[$];

`ifdef SAMPLER_TOGGLE_COUNT_EN
    localparam logic [15:0] T3_TC = 16'd7;
`else
    localparam logic [15:0] T3_TC = 16'd0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (dut_in == 4'h7) tog <= ~tog;

    assign dut_out = (mode == 0) ? 1'b1 :
                     (mode == 2 && dut_in == 4'h7) ? tog :
                     (dut_in[0] ^ dut_in[3]);

    evo_truth_table_sampler u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dut_in(dut_in), .dut_out(dut_out),
        .busy(busy), .done(done), .truth_table(truth_table),
        .unstable_mask(unstable_mask), .toggle_count(toggle_count)
    );

    evo_truth_table_sampler #(.SETTLE_CYCLES(2), .SAMPLES(1)) u_dut_min (
        .clk(clk), .rst_n(rst_n), .start(start2), .dut_in(dut_in2), .dut_out(dut_out2),
        .busy(busy2), .done(done2), .truth_table(truth_table2),
        .unstable_mask(unstable_mask2), .toggle_count(toggle_count2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one sweep on the default instance. repulse_vec >= 0 re-pulses
    // start when that vector is being applied.
    task automatic run_sweep(input string name, input logic [15:0] ett,
                             input logic [15:0] ecare, input logic [15:0] eum,
                             input logic [15:0] etc, input int repulse_vec);
        exp_t e, got_e;
        int   k;
        int   extra;
        bit   got;
        bit   pulsed;
        logic [3:0] prev;
        @(negedge clk) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = cyc - 1;                       // start edge; DUT reacts from k+1
        e.tt = ett; e.tt_care = ecare; e.um = eum; e.tc = etc; e.done_at = k + 385;
        sb.push_back(e);
        check({name, "_busy_on_start"}, {31'd0, busy}, 32'd1);
        check({name, "_vec0"}, {28'd0, dut_in}, 32'd0);
        prev = dut_in; got = 1'b0; pulsed = 1'b0;
        for (int i = 0; i < 450 && !got; i++) begin
            @(posedge clk); #1;
            if (start) start = 1'b0;
            if (dut_in !== prev) begin
                check({name, "_vec_step"}, {28'd0, dut_in}, {28'd0, prev + 4'h1});
                check({name, "_vec_time"}, cyc, k + 1 + 24 * int'(dut_in));
                prev = dut_in;
            end
            if (repulse_vec >= 0 && int'(dut_in) == repulse_vec && !pulsed) begin
                start = 1'b1;
                pulsed = 1'b1;
            end
            if (done) begin
                got = 1'b1;
                got_e = sb.pop_front();
                check({name, "_done_time"}, cyc, got_e.done_at);
                check({name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
                check({name, "_truth_table"}, {16'd0, truth_table & got_e.tt_care},
                      {16'd0, got_e.tt & got_e.tt_care});
                check({name, "_unstable"}, {16'd0, unstable_mask}, {16'd0, got_e.um});
                check({name, "_toggles"}, {16'd0, toggle_count}, {16'd0, got_e.tc});
            end
        end
        check({name, "_done_seen"}, {31'd0, got}, 32'd1);
        extra = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        check({name, "_single_done"}, extra, 0);
        check({name, "_idle_after"}, {31'd0, busy}, 32'd0);
        check({name, "_tt_hold"}, {16'd0, truth_table & ecare}, {16'd0, ett & ecare});
        $display("sweep %s: tt=%h um=%h tc=%0d", name, truth_table, unstable_mask, toggle_count);
    endtask

    initial begin
        int k2;
        int dn;
        bit got2;
        bit reached;
        exp_t e2, g2;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_dut_in", {28'd0, dut_in}, 32'd0);
        check("rst_busy_done", {30'd0, busy, done}, 32'd0);
        check("rst_tt", {16'd0, truth_table}, 32'd0);
        check("rst_um", {16'd0, unstable_mask}, 32'd0);
        check("rst_tc", {16'd0, toggle_count}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // T1: constant-1 circuit
        mode = 0;
        run_sweep("t1", 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, -1);

        // T2: out = in0 ^ in3
        mode = 1;
        run_sweep("t2", 16'h55AA, 16'hFFFF, 16'h0000, 16'h0000, -1);

        // T3: vector 7 oscillates every clock; its first sample depends on phase
        mode = 2;
        run_sweep("t3", 16'h55AA, 16'hFF7F, 16'h0080, T3_TC, -1);

        // T4: start re-pulsed during vector 5 is ignored
        mode = 1;
        run_sweep("t4", 16'h55AA, 16'hFFFF, 16'h0000, 16'h0000, 5);

        // T5: reset during vector 9 aborts the sweep
        mode = 1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 400 && !reached; i++) begin
            @(posedge clk); #1;
            if (dut_in == 4'h9) reached = 1'b1;
        end
        check("t5_reach_vec9", {31'd0, reached}, 32'd1);
        repeat (4) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        #1;
        check("t5_async_dut_in", {28'd0, dut_in}, 32'd0);
        check("t5_async_busy", {31'd0, busy}, 32'd0);
        check("t5_async_tt", {16'd0, truth_table}, 32'd0);
        check("t5_async_um", {16'd0, unstable_mask}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 420; i++) begin
            @(posedge clk); #1;
            if (done || busy) dn++;
        end
        check("t5_no_done_after_abort", dn, 0);
        $display("reset abort at vector 9: activity cycles after release %0d", dn);
        run_sweep("t5_rerun", 16'h55AA, 16'hFFFF, 16'h0000, 16'h0000, -1);

        // T6: SETTLE_CYCLES=2, SAMPLES=1, constant-0 circuit
        @(negedge clk) start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        k2 = cyc - 1;
        e2.tt = 16'h0000; e2.tt_care = 16'hFFFF; e2.um = 16'h0000; e2.tc = 16'h0000;
        e2.done_at = k2 + 49;
        sb.push_back(e2);
        got2 = 1'b0;
        for (int i = 0; i < 100 && !got2; i++) begin
            @(posedge clk); #1;
            if (done2) begin
                got2 = 1'b1;
                g2 = sb.pop_front();
                check("t6_done_time", cyc, g2.done_at);
                check("t6_truth_table", {16'd0, truth_table2}, {16'd0, g2.tt});
                check("t6_unstable", {16'd0, unstable_mask2}, {16'd0, g2.um});
                check("t6_toggles", {16'd0, toggle_count2}, {16'd0, g2.tc});
                check("t6_vec_final", {28'd0, dut_in2}, 32'd15);
            end
        end
        check("t6_done_seen", {31'd0, got2}, 32'd1);
        $display("sweep t6: tt=%h um=%h", truth_table2, unstable_mask2);

        check("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
